pipeline_sequencer: RTL and testbench

//  Sequences the 5-stage MIPS pipeline: drives per-stage *_rst/*_en, reg_stall and final pc_src_ctrl.

---
 rtl/pipeline_sequencer_pkg.sv | 46 ++++
 rtl/pipeline_sequencer_hazard.sv | 20 ++
 rtl/pipeline_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline sequencer: FSM states, PC select codes and the
// per-cycle stage control bundle, plus the RUN-state priority rules.
package pipeline_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_INIT,
        SEQ_RUN,
        SEQ_MEMWAIT,
        SEQ_HALT,
        SEQ_STEP
    } seq_state_t;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;

    // Stage vectors are ordered {if, id, exe, mem, wb}.
    typedef struct packed {
        logic [4:0] rst;
        logic [4:0] en;
        logic       reg_stall;
        logic [1:0] pc_src;
    } seq_ctrl_t;

    localparam seq_ctrl_t CTRL_FLUSH = '{rst: 5'b11111, en: 5'b00000, reg_stall: 1'b0, pc_src: PC_NEXT};
    localparam seq_ctrl_t CTRL_IDLE  = '{rst: 5'b00000, en: 5'b00000, reg_stall: 1'b0, pc_src: PC_NEXT};

    function automatic seq_ctrl_t run_ctrl(input logic mem_stall, input logic load_use,
                                           input logic [1:0] pc_src_req);
        seq_ctrl_t c;
        c = '{rst: 5'b00000, en: 5'b11111, reg_stall: 1'b0, pc_src: PC_NEXT};
        if (mem_stall) begin
            c.en = 5'b00000;
        end else if (load_use) begin
            // Bubble into EXE; a pending redirect is dropped and re-issued after the stall.
            c.en        = 5'b00111;
            c.rst       = 5'b00100;
            c.reg_stall = 1'b1;
        end else if (pc_src_req != PC_NEXT) begin
            c.pc_src = pc_src_req;
            c.rst    = 5'b01000;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard.sv
// Combinational load-use hazard detect between the ID instruction and a load in EXE.
module pipe_seq_hazard (
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic [4:0] addr_rs,
    input  logic [4:0] addr_rt,
    input  logic       is_load,
    input  logic       wb_wen,
    input  logic [4:0] regw_addr,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = rs_used & (addr_rs == regw_addr);
    assign rt_hit   = rt_used & (addr_rt == regw_addr);
    assign load_use = is_load & wb_wen & (regw_addr != 5'd0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_sequencer.sv
// 5-stage pipeline sequencer: flush, load-use bubbles, redirect squash, MEM wait/timeout,
// debug halt/step. Optional performance counters under PIPE_PERF_CNT_EN.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int RST_FLUSH_CYCLES = 5,
    parameter int MEM_TIMEOUT      = 255,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             step_req,
    input  logic [1:0]       pc_src_req,
    input  logic             rs_used_ctrl,
    input  logic             rt_used_ctrl,
    input  logic [4:0]       addr_rs,
    input  logic [4:0]       addr_rt,
    input  logic             is_load_exe,
    input  logic             wb_wen_exe,
    input  logic [4:0]       regw_addr_exe,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             reg_stall,
    output logic [1:0]       pc_src_ctrl,
    output logic             halted,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_flushes,
`endif
    output logic             mem_err
);

    localparam int FW = (RST_FLUSH_CYCLES > 1) ? $clog2(RST_FLUSH_CYCLES) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(RST_FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    seq_state_t    state, state_next;
    logic [FW-1:0] flush_cnt, flush_next;
    logic [WW-1:0] wait_cnt, wait_next;
    logic          err_next;
    logic          step_wait, step_wait_next;
    logic          load_use;
    logic          mem_stall;
    seq_ctrl_t     ctrl;
    logic          halted_int;

    assign mem_stall = mem_req & ~mem_ack;

    pipe_seq_hazard u_hazard (
        .rs_used   (rs_used_ctrl),
        .rt_used   (rt_used_ctrl),
        .addr_rs   (addr_rs),
        .addr_rt   (addr_rt),
        .is_load   (is_load_exe),
        .wb_wen    (wb_wen_exe),
        .regw_addr (regw_addr_exe),
        .load_use  (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_INIT;
            flush_cnt <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            step_wait <= 1'b0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_next;
            wait_cnt  <= wait_next;
            mem_err   <= err_next;
            step_wait <= step_wait_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_next     = flush_cnt;
        wait_next      = wait_cnt;
        err_next       = mem_err;
        step_wait_next = step_wait;
        case (state)
            SEQ_INIT: begin
                if (flush_cnt == FLUSH_LAST) begin
                    flush_next = '0;
                    state_next = run_en ? SEQ_RUN : SEQ_HALT;
                end else begin
                    flush_next = flush_cnt + FW'(1);
                end
            end
            SEQ_RUN: begin
                if (mem_stall) begin
                    state_next     = SEQ_MEMWAIT;
                    step_wait_next = 1'b0;
                    wait_next      = '0;
                end else if (!run_en) begin
                    state_next = SEQ_HALT;
                end
            end
            SEQ_MEMWAIT: begin
                if (mem_ack) begin
                    wait_next  = '0;
                    state_next = (step_wait || !run_en) ? SEQ_HALT : SEQ_RUN;
                end else if (MEM_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
                    wait_next  = '0;
                    err_next   = 1'b1;
                    state_next = SEQ_HALT;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_next = wait_cnt + WW'(1);
                end
            end
            SEQ_HALT: begin
                if (!mem_err) begin
                    if (run_en) begin
                        state_next = SEQ_RUN;
                    end else if (step_req) begin
                        state_next = SEQ_STEP;
                    end
                end
            end
            SEQ_STEP: begin
                if (mem_stall) begin
                    state_next     = SEQ_MEMWAIT;
                    step_wait_next = 1'b1;
                    wait_next      = '0;
                end else begin
                    state_next = SEQ_HALT;
                end
            end
            default: state_next = SEQ_INIT;
        endcase
    end

    always_comb begin
        ctrl       = CTRL_IDLE;
        halted_int = 1'b0;
        case (state)
            SEQ_INIT:    ctrl = CTRL_FLUSH;
            SEQ_RUN,
            SEQ_STEP:    ctrl = run_ctrl(mem_stall, load_use, pc_src_req);
            SEQ_MEMWAIT: if (mem_ack) ctrl = run_ctrl(1'b0, load_use, pc_src_req);
            SEQ_HALT:    halted_int = 1'b1;
            default:     ctrl = CTRL_FLUSH;
        endcase
    end

    assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = ctrl.rst;
    assign {if_en, id_en, exe_en, mem_en, wb_en}      = ctrl.en;
    assign reg_stall   = ctrl.reg_stall;
    assign pc_src_ctrl = ctrl.pc_src;
    assign halted      = halted_int;

`ifdef PIPE_PERF_CNT_EN
    logic cyc_hit, stall_hit, flush_hit;

    assign cyc_hit   = (state == SEQ_RUN) || (state == SEQ_STEP);
    assign stall_hit = ctrl.reg_stall || (state == SEQ_MEMWAIT);
    assign flush_hit = ctrl.rst[3] && (state != SEQ_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else begin
            if (cyc_hit && perf_cycles != '1)    perf_cycles  <= perf_cycles + CNT_W'(1);
            if (stall_hit && perf_stalls != '1)  perf_stalls  <= perf_stalls + CNT_W'(1);
            if (flush_hit && perf_flushes != '1) perf_flushes <= perf_flushes + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed table-driven bench for pipeline_sequencer plus multi-cycle corner sequences.
module tb_pipeline_sequencer;

    logic       clk, rst_n, run_en, step_req;
    logic [1:0] pc_src_req;
    logic       rs_used_ctrl, rt_used_ctrl;
    logic [4:0] addr_rs, addr_rt, regw_addr_exe;
    logic       is_load_exe, wb_wen_exe, mem_req, mem_ack;
    logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic       reg_stall, halted, mem_err;
    logic [1:0] pc_src_ctrl;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_cycles, perf_stalls, perf_flushes;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected vector: {rst[5], en[5], reg_stall, pc_src[2], halted, mem_err}
    localparam logic [14:0] E_INIT  = {5'b11111, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [14:0] E_RUN   = {5'b00000, 5'b11111, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [14:0] E_FRZ   = {5'b00000, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [14:0] E_LU    = {5'b00100, 5'b00111, 1'b1, 2'd0, 1'b0, 1'b0};
    localparam logic [14:0] E_BR    = {5'b01000, 5'b11111, 1'b0, 2'd2, 1'b0, 1'b0};
    localparam logic [14:0] E_JMP   = {5'b01000, 5'b11111, 1'b0, 2'd1, 1'b0, 1'b0};
    localparam logic [14:0] E_HALT  = {5'b00000, 5'b00000, 1'b0, 2'd0, 1'b1, 1'b0};
    localparam logic [14:0] E_ERR   = {5'b00000, 5'b00000, 1'b0, 2'd0, 1'b1, 1'b1};

    pipeline_sequencer #(
        .RST_FLUSH_CYCLES (5),
        .MEM_TIMEOUT      (8),
        .CNT_W            (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_en        (run_en),
        .step_req      (step_req),
        .pc_src_req    (pc_src_req),
        .rs_used_ctrl  (rs_used_ctrl),
        .rt_used_ctrl  (rt_used_ctrl),
        .addr_rs       (addr_rs),
        .addr_rt       (addr_rt),
        .is_load_exe   (is_load_exe),
        .wb_wen_exe    (wb_wen_exe),
        .regw_addr_exe (regw_addr_exe),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .if_rst        (if_rst),
        .id_rst        (id_rst),
        .exe_rst       (exe_rst),
        .mem_rst       (mem_rst),
        .wb_rst        (wb_rst),
        .if_en         (if_en),
        .id_en         (id_en),
        .exe_en        (exe_en),
        .mem_en        (mem_en),
        .wb_en         (wb_en),
        .reg_stall     (reg_stall),
        .pc_src_ctrl   (pc_src_ctrl),
        .halted        (halted),
`ifdef PIPE_PERF_CNT_EN
        .perf_cycles   (perf_cycles),
        .perf_stalls   (perf_stalls),
        .perf_flushes  (perf_flushes),
`endif
        .mem_err       (mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [1:0]  pc_req;
        logic        rs_used;
        logic        rt_used;
        logic [4:0]  a_rs;
        logic [4:0]  a_rt;
        logic        ld;
        logic        wen;
        logic [4:0]  regw;
        logic        mreq;
        logic        mack;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {if_rst, id_rst, exe_rst, mem_rst, wb_rst, if_en, id_en, exe_en, mem_en, wb_en,
               reg_stall, pc_src_ctrl, halted, mem_err};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic set_idle();
        step_req = 1'b0; pc_src_req = 2'd0;
        rs_used_ctrl = 1'b0; rt_used_ctrl = 1'b0; addr_rs = 5'd0; addr_rt = 5'd0;
        is_load_exe = 1'b0; wb_wen_exe = 1'b0; regw_addr_exe = 5'd0;
        mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic flush_then_run(input string name);
        for (int i = 0; i < 5; i++) begin
            #3 check({name, "_flush"}, E_INIT);
            tick();
        end
        #3 check({name, "_first_run"}, E_RUN);
    endtask

    initial begin
        vecs[0]  = '{"idle",       2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_RUN};
        vecs[1]  = '{"lu_rs",      2'd0, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, E_LU};
        vecs[2]  = '{"lu_rt",      2'd0, 1'b0, 1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, E_LU};
        vecs[3]  = '{"lu_r0",      2'd0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, E_RUN};
        vecs[4]  = '{"rs_unused",  2'd0, 1'b0, 1'b0, 5'd4, 5'd4, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, E_RUN};
        vecs[5]  = '{"not_load",   2'd0, 1'b1, 1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_RUN};
        vecs[6]  = '{"no_wen",     2'd0, 1'b1, 1'b0, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, E_RUN};
        vecs[7]  = '{"branch",     2'd2, 1'b1, 1'b0, 5'd9, 5'd0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, E_BR};
        vecs[8]  = '{"jump",       2'd1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_JMP};
        vecs[9]  = '{"branch_lu",  2'd2, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, E_LU};
        vecs[10] = '{"mem_ack_1c", 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_RUN};

        rst_n = 1'b0; run_en = 1'b1; set_idle();

        // Power-on reset and flush
        tick();
        #1 check("reset_hold", E_INIT);
        tick(); tick();
        rst_n = 1'b1;
        flush_then_run("por");
        tick();

        // Single-cycle RUN vectors
        foreach (vecs[i]) begin
            pc_src_req = vecs[i].pc_req; rs_used_ctrl = vecs[i].rs_used; rt_used_ctrl = vecs[i].rt_used;
            addr_rs = vecs[i].a_rs; addr_rt = vecs[i].a_rt; is_load_exe = vecs[i].ld;
            wb_wen_exe = vecs[i].wen; regw_addr_exe = vecs[i].regw;
            mem_req = vecs[i].mreq; mem_ack = vecs[i].mack;
            #3 check(vecs[i].name, vecs[i].exp);
            tick();
        end
        set_idle();

        // MEM wait: 4 stalled cycles then ack
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3 check("memwait_frozen", E_FRZ);
            tick();
        end
        mem_ack = 1'b1;
        #3 check("memwait_ack", E_RUN);
        tick();
        set_idle();
        #3 check("memwait_back_run", E_RUN);

        // Halt, single step
        run_en = 1'b0;
        #1 check("halt_last_adv", E_RUN);
        tick();
        #3 check("halted", E_HALT);
        step_req = 1'b1;
        #1 check("step_req_cycle", E_HALT);
        tick();
        step_req = 1'b0;
        #3 check("step_cycle", E_RUN);
        tick();
        #3 check("step_rehalt", E_HALT);
        tick();
        #3 check("step_stay_halt", E_HALT);

        // run_en with step_req -> RUN, not a single step
        run_en = 1'b1; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        #3 check("run_step_run1", E_RUN);
        tick();
        #3 check("run_step_run2", E_RUN);
        run_en = 1'b0;
        tick();
        #3 check("halt_again", E_HALT);

        // Step into MEMWAIT returns to HALT on ack
        step_req = 1'b1;
        tick();
        step_req = 1'b0; mem_req = 1'b1;
        #3 check("step_mem_frozen", E_FRZ);
        tick();
        #3 check("step_memwait", E_FRZ);
        mem_ack = 1'b1;
        #1 check("step_mem_ack", E_RUN);
        tick();
        set_idle();
        #3 check("step_mem_rehalt", E_HALT);

        // Timeout: 8 MEMWAIT cycles then sticky mem_err
        run_en = 1'b1;
        tick();
        #3 check("resume_run", E_RUN);
        mem_req = 1'b1;
        #1 check("to_enter", E_FRZ);
        tick();
        for (int i = 0; i < 8; i++) begin
            #3 check("to_wait", E_FRZ);
            tick();
        end
        #3 check("to_err", E_ERR);
        step_req = 1'b1;
        tick();
        tick();
        #3 check("err_sticky", E_ERR);

        // Reset clears mem_err and restarts flush
        rst_n = 1'b0;
        #1 check("err_reset", E_INIT);
        tick();
        rst_n = 1'b1; set_idle();
        flush_then_run("post_err");

        // Reset asserted mid-MEMWAIT
        mem_req = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1 check("memwait_reset", E_INIT);
        tick();
        rst_n = 1'b1; set_idle();
        flush_then_run("post_memwait");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
